// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline hazard controller.
//   state_e   : memory-wait tracking FSM states
//   FWD_*     : EX operand forward-select encodings
//   ctrl_t    : bundle of pipeline-register stall/flush controls
//   CTRL_NOP  : all controls inactive
package pipe_pkg;

  typedef enum logic [0:0] {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } state_e;

  localparam logic [1:0] FWD_RF    = 2'd0;
  localparam logic [1:0] FWD_EXMEM = 2'd1;
  localparam logic [1:0] FWD_MEMWB = 2'd2;

  typedef struct packed {
    logic stall_if;
    logic stall_id;
    logic stall_ex;
    logic stall_mem;
    logic flush_id;
    logic flush_ex;
    logic bubble_wb;
  } ctrl_t;

  localparam ctrl_t CTRL_NOP = '0;

endpackage

// File: rtl/fwd_unit.sv
// Operand forward-select for one EX source register (purely combinational).
//   ex_rs                : source register of the EX instruction
//   exmem_rd, exmem_wreg : destination / write enable of the MEM instruction
//   memwb_rd, memwb_wreg : destination / write enable of the WB instruction
//   fwd                  : FWD_RF, FWD_EXMEM or FWD_MEMWB
module fwd_unit
  import pipe_pkg::*;
(
  input  logic [4:0] ex_rs,
  input  logic [4:0] exmem_rd,
  input  logic       exmem_wreg,
  input  logic [4:0] memwb_rd,
  input  logic       memwb_wreg,
  output logic [1:0] fwd
);

  // The younger producer (EX/MEM) holds the newer value, so it wins.
  always_comb begin
    fwd = FWD_RF;
    if (exmem_wreg && (exmem_rd != 5'd0) && (exmem_rd == ex_rs)) begin
      fwd = FWD_EXMEM;
    end else if (memwb_wreg && (memwb_rd != 5'd0) && (memwb_rd == ex_rs)) begin
      fwd = FWD_MEMWB;
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central hazard controller for the 5-stage IF/ID/EX/MEM/WB pipeline.
//   Inputs : ID/EX/MEM/WB register ids and write/load flags, ex_redirect,
//            mem_req / mem_ready handshake with data memory.
//   Outputs: fwd_a / fwd_b operand selects, per-register stall/flush controls,
//            bubble_wb, sticky mem_timeout, saturating stall_cnt / flush_cnt.
// Control outputs are combinational; FSM, wait counter, timeout flag and
// counters update on the rising edge of clk and reset asynchronously on rst.
module pipe_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int unsigned TIMEOUT = 64,
  parameter int unsigned CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       dec_rs1,
  input  logic [4:0]       dec_rs2,
  input  logic             dec_use_rs1,
  input  logic             dec_use_rs2,
  input  logic [4:0]       idex_rs1,
  input  logic [4:0]       idex_rs2,
  input  logic [4:0]       idex_rd,
  input  logic             idex_wreg,
  input  logic             idex_rmem,
  input  logic [4:0]       exmem_rd,
  input  logic             exmem_wreg,
  input  logic [4:0]       memwb_rd,
  input  logic             memwb_wreg,
  input  logic             ex_redirect,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic             stall_if,
  output logic             stall_id,
  output logic             stall_ex,
  output logic             stall_mem,
  output logic             flush_id,
  output logic             flush_ex,
  output logic             bubble_wb,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int unsigned      WaitW   = $clog2(TIMEOUT + 1);
  localparam logic [WaitW-1:0] WaitMax = WaitW'(TIMEOUT);

  // Forwarding
  fwd_unit u_fwd_a (
    .ex_rs      (idex_rs1),
    .exmem_rd   (exmem_rd),
    .exmem_wreg (exmem_wreg),
    .memwb_rd   (memwb_rd),
    .memwb_wreg (memwb_wreg),
    .fwd        (fwd_a)
  );

  fwd_unit u_fwd_b (
    .ex_rs      (idex_rs2),
    .exmem_rd   (exmem_rd),
    .exmem_wreg (exmem_wreg),
    .memwb_rd   (memwb_rd),
    .memwb_wreg (memwb_wreg),
    .fwd        (fwd_b)
  );

  // Hazard detection
  logic memwait;
  logic loaduse;
  logic redirect_svc;

  assign memwait = mem_req & ~mem_ready;
  assign loaduse = idex_rmem & idex_wreg & (idex_rd != 5'd0) &
                   ((dec_use_rs1 & (dec_rs1 == idex_rd)) |
                    (dec_use_rs2 & (dec_rs2 == idex_rd)));
  // A redirect during a memory wait stays parked in EX until the wait ends.
  assign redirect_svc = ex_redirect & ~memwait;

  ctrl_t ctrl;

  always_comb begin
    ctrl = CTRL_NOP;
    if (memwait) begin
      // Freeze everything up to MEM; WB gets a bubble since MEM produces nothing.
      ctrl.stall_if  = 1'b1;
      ctrl.stall_id  = 1'b1;
      ctrl.stall_ex  = 1'b1;
      ctrl.stall_mem = 1'b1;
      ctrl.bubble_wb = 1'b1;
    end else if (ex_redirect) begin
      // Loaduse is irrelevant here: the ID instruction is discarded anyway.
      ctrl.flush_id = 1'b1;
      ctrl.flush_ex = 1'b1;
    end else if (loaduse) begin
      ctrl.stall_if = 1'b1;
      ctrl.stall_id = 1'b1;
      ctrl.flush_ex = 1'b1;
    end
  end

  assign stall_if  = ctrl.stall_if;
  assign stall_id  = ctrl.stall_id;
  assign stall_ex  = ctrl.stall_ex;
  assign stall_mem = ctrl.stall_mem;
  assign flush_id  = ctrl.flush_id;
  assign flush_ex  = ctrl.flush_ex;
  assign bubble_wb = ctrl.bubble_wb;

  // Memory wait FSM, wait counter and timeout flag
  state_e           state_q, state_d;
  logic [WaitW-1:0] wait_cnt_q, wait_cnt_d;
  logic             timeout_q, timeout_d;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RUN:      if (memwait) state_d = MEM_WAIT;
      MEM_WAIT: if (mem_ready || !mem_req) state_d = RUN;
      default:  state_d = RUN;
    endcase
  end

  always_comb begin
    wait_cnt_d = '0;
    if (memwait) begin
      wait_cnt_d = (wait_cnt_q == WaitMax) ? wait_cnt_q : wait_cnt_q + 1'b1;
    end
    timeout_d = timeout_q | (wait_cnt_d == WaitMax);
  end

  // Performance counters (saturating)
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (ctrl.stall_if && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + 1'b1;
    if (redirect_svc && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= RUN;
      wait_cnt_q  <= '0;
      timeout_q   <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      timeout_q   <= timeout_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign mem_timeout = timeout_q;
  assign stall_cnt   = stall_cnt_q;
  assign flush_cnt   = flush_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed self-checking bench for pipe_hazard_ctrl (TIMEOUT=8, CNT_W=4).
module tb_pipe_hazard_ctrl;
  import pipe_pkg::*;

  localparam int unsigned TIMEOUT = 8;
  localparam int unsigned CNT_W   = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic [4:0]       dec_rs1, dec_rs2, idex_rs1, idex_rs2, idex_rd, exmem_rd, memwb_rd;
  logic             dec_use_rs1, dec_use_rs2, idex_wreg, idex_rmem, exmem_wreg, memwb_wreg;
  logic             ex_redirect, mem_req, mem_ready;
  logic [1:0]       fwd_a, fwd_b;
  logic             stall_if, stall_id, stall_ex, stall_mem;
  logic             flush_id, flush_ex, bubble_wb, mem_timeout;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(
    .TIMEOUT (TIMEOUT),
    .CNT_W   (CNT_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .dec_rs1     (dec_rs1),
    .dec_rs2     (dec_rs2),
    .dec_use_rs1 (dec_use_rs1),
    .dec_use_rs2 (dec_use_rs2),
    .idex_rs1    (idex_rs1),
    .idex_rs2    (idex_rs2),
    .idex_rd     (idex_rd),
    .idex_wreg   (idex_wreg),
    .idex_rmem   (idex_rmem),
    .exmem_rd    (exmem_rd),
    .exmem_wreg  (exmem_wreg),
    .memwb_rd    (memwb_rd),
    .memwb_wreg  (memwb_wreg),
    .ex_redirect (ex_redirect),
    .mem_req     (mem_req),
    .mem_ready   (mem_ready),
    .fwd_a       (fwd_a),
    .fwd_b       (fwd_b),
    .stall_if    (stall_if),
    .stall_id    (stall_id),
    .stall_ex    (stall_ex),
    .stall_mem   (stall_mem),
    .flush_id    (flush_id),
    .flush_ex    (flush_ex),
    .bubble_wb   (bubble_wb),
    .mem_timeout (mem_timeout),
    .stall_cnt   (stall_cnt),
    .flush_cnt   (flush_cnt)
  );

  task automatic chk(input string tag, input int unsigned obs, input int unsigned exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Packs {stall_if,stall_id,stall_ex,stall_mem,flush_id,flush_ex,bubble_wb}.
  function automatic int unsigned ctl();
    return int'({stall_if, stall_id, stall_ex, stall_mem, flush_id, flush_ex, bubble_wb});
  endfunction

  task automatic clear_inputs();
    {dec_rs1, dec_rs2, idex_rs1, idex_rs2, idex_rd, exmem_rd, memwb_rd} = '0;
    {dec_use_rs1, dec_use_rs2, idex_wreg, idex_rmem, exmem_wreg, memwb_wreg} = '0;
    {ex_redirect, mem_req, mem_ready} = '0;
  endtask

  // Advance one rising edge, then settle away from it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    clear_inputs();
    rst = 1'b1;
    #12;
    chk("reset_ctl", ctl(), 0);
    chk("reset_fwd", int'({fwd_a, fwd_b}), 0);
    chk("reset_cnts", int'({stall_cnt, flush_cnt}), 0);
    chk("reset_timeout", int'(mem_timeout), 0);
    @(negedge clk);
    rst = 1'b0;

    // Forwarding
    exmem_rd = 5; exmem_wreg = 1; memwb_rd = 5; memwb_wreg = 1; idex_rs1 = 5;
    #1 chk("fwd_both_match", int'(fwd_a), 1);
    chk("fwd_b_rf", int'(fwd_b), 0);
    exmem_rd = 0; idex_rs2 = 5;
    #1 chk("fwd_rd0_memwb", int'(fwd_a), 2);
    chk("fwd_b_memwb", int'(fwd_b), 2);
    memwb_wreg = 0;
    #1 chk("fwd_no_wreg", int'(fwd_a), 0);
    clear_inputs();

    // Load-use: one stall cycle, consumer then forwards from MEM/WB
    idex_rmem = 1; idex_wreg = 1; idex_rd = 3; dec_rs2 = 3; dec_use_rs2 = 1;
    #1 chk("loaduse_ctl", ctl(), 7'b1100010);
    tick();
    clear_inputs();
    idex_rs2 = 3; memwb_rd = 3; memwb_wreg = 1;
    #1 chk("after_loaduse_ctl", ctl(), 0);
    chk("consumer_fwd_b", int'(fwd_b), 2);
    chk("stall_cnt_1", int'(stall_cnt), 1);
    clear_inputs();

    // Redirect with loaduse: redirect wins
    idex_rmem = 1; idex_wreg = 1; idex_rd = 7; dec_rs1 = 7; dec_use_rs1 = 1;
    ex_redirect = 1;
    #1 chk("redirect_ctl", ctl(), 7'b0000110);
    tick();
    chk("flush_cnt_1", int'(flush_cnt), 1);
    chk("stall_cnt_still_1", int'(stall_cnt), 1);
    clear_inputs();

    // Memory wait for 3 cycles with a parked redirect
    mem_req = 1; ex_redirect = 1;
    for (int i = 0; i < 3; i++) begin
      #1 chk("memwait_ctl", ctl(), 7'b1111001);
      tick();
      chk("memwait_state", int'(dut.state_q), int'(MEM_WAIT));
    end
    mem_ready = 1;
    #1 chk("release_ctl", ctl(), 7'b0000110);
    tick();
    chk("release_state", int'(dut.state_q), int'(RUN));
    chk("flush_cnt_2", int'(flush_cnt), 2);
    chk("stall_cnt_4", int'(stall_cnt), 4);
    clear_inputs();

    // Timeout: flag sets on the TIMEOUT-th waiting edge
    mem_req = 1;
    for (int i = 0; i < 7; i++) tick();
    chk("timeout_before", int'(mem_timeout), 0);
    tick();
    chk("timeout_set", int'(mem_timeout), 1);
    chk("timeout_stall", ctl(), 7'b1111001);
    mem_ready = 1;
    tick();
    chk("timeout_sticky", int'(mem_timeout), 1);
    chk("stall_cnt_12", int'(stall_cnt), 12);
    chk("wait_cnt_clear", int'(dut.wait_cnt_q), 0);

    // Asynchronous reset in the middle of a wait
    mem_ready = 0;
    tick();
    tick();
    #2 rst = 1'b1;
    #1 chk("arst_cnts", int'({stall_cnt, flush_cnt}), 0);
    chk("arst_timeout", int'(mem_timeout), 0);
    chk("arst_state", int'(dut.state_q), int'(RUN));
    chk("arst_stall_follows_inputs", ctl(), 7'b1111001);
    clear_inputs();
    #1 chk("arst_inputs_low", ctl(), 0);
    @(negedge clk);
    rst = 1'b0;

    // Saturation of stall counter and wait counter
    mem_req = 1;
    for (int i = 0; i < 20; i++) tick();
    chk("stall_cnt_sat", int'(stall_cnt), 15);
    chk("wait_cnt_sat", int'(dut.wait_cnt_q), TIMEOUT);
    chk("timeout_after_sat", int'(mem_timeout), 1);
    clear_inputs();
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Central hazard controller for the 5-stage pipeline (IF/ID/EX/MEM/WB). It decides, every cycle:
- operand forwarding selects for the instruction in EX;
- stall and flush controls for every pipeline register;
- when to freeze the pipe on data-memory wait states.

It keeps a small FSM for memory wait tracking, a timeout flag, and saturating stall/flush performance counters.

## Interface
Parameters:
- TIMEOUT, 64: consecutive memory wait cycles before mem_timeout is set.
- CNT_W, 32: performance counter width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- dec_rs1, dec_rs2  in  5  source registers of the instruction in ID.
- dec_use_rs1, dec_use_rs2  in  1  ID instruction actually reads that source.
- idex_rs1, idex_rs2  in  5  source registers of the instruction in EX.
- idex_rd  in  5  destination of the EX instruction.
- idex_wreg, idex_rmem  in  1  EX instruction writes a register / is a load.
- exmem_rd  in  5  destination of the MEM instruction.
- exmem_wreg  in  1  MEM instruction writes a register.
- memwb_rd  in  5  destination of the WB instruction.
- memwb_wreg  in  1  WB instruction writes a register.
- ex_redirect  in  1  taken branch or jump resolved in EX.
- mem_req  in  1  MEM instruction accesses data memory.
- mem_ready  in  1  data memory completes the access this cycle.
- fwd_a, fwd_b  out  2  EX operand select: 0 = register file, 1 = EX/MEM ALU result, 2 = MEM/WB writeback value; 3 is never driven.
- stall_if, stall_id, stall_ex, stall_mem  out  1  hold the PC / IF-ID / ID-EX / EX-MEM register.
- flush_id, flush_ex  out  1  load a NOP into IF-ID / ID-EX (all control bits 0).
- bubble_wb  out  1  MEM-WB register loads a NOP.
- mem_timeout  out  1  sticky timeout flag.
- stall_cnt, flush_cnt  out  CNT_W  performance counters.

## Operation
All control outputs are combinational from the inputs and the registered state.

Forwarding (fwd_a; fwd_b is identical using idex_rs2):
- Select 1 if exmem_wreg, exmem_rd != 0 and exmem_rd == idex_rs1.
- Otherwise select 2 if memwb_wreg, memwb_rd != 0 and memwb_rd == idex_rs1.
- Otherwise select 0. EX/MEM wins when both stages match.

Hazard terms:
- memwait = mem_req & !mem_ready.
- loaduse = idex_rmem & idex_wreg & idex_rd != 0 & ((dec_use_rs1 & dec_rs1 == idex_rd) | (dec_use_rs2 & dec_rs2 == idex_rd)).

Priority, highest first:
1. memwait: stall_if, stall_id, stall_ex, stall_mem = 1; bubble_wb = 1; no flushes. A redirect arriving during the wait stays held in EX and is serviced on the cycle memwait drops.
2. ex_redirect: flush_id = 1, flush_ex = 1, no stalls. A simultaneous loaduse is suppressed because the ID instruction is being discarded.
3. loaduse: stall_if = 1, stall_id = 1, flush_ex = 1 (one bubble). stall_ex = 0.
4. Otherwise all outputs are 0.

FSM, states RUN and MEM_WAIT:
- RUN -> MEM_WAIT when memwait.
- MEM_WAIT stays while memwait.
- MEM_WAIT -> RUN when mem_ready is 1 or mem_req is 0.

Wait counter:
- wait_cnt (width clog2(TIMEOUT+1)) increments on every cycle with memwait, saturating at TIMEOUT.
- It clears on the cycle memwait is 0.
- mem_timeout sets on the cycle wait_cnt reaches TIMEOUT and holds until rst. Setting it does not alter the stall behaviour.

Performance counters:
- stall_cnt increments on any cycle with stall_if = 1.
- flush_cnt increments on any cycle with ex_redirect serviced (priority 2 active).
- Both saturate at all-ones.

## Timing
- Forward, stall and flush outputs have zero latency: they respond in the same cycle as their inputs.
- The FSM, wait counter, timeout flag and performance counters update on the clock edge.
- Reset (asynchronous): state RUN, wait_cnt 0, mem_timeout 0, stall_cnt 0, flush_cnt 0. With all-zero inputs every output is 0.
- Reset mid-wait returns the FSM to RUN immediately and drops the stall outputs once the inputs drop.
- A load-use hazard costs exactly 1 stall cycle; the consumer then takes fwd = 2.
- A redirect costs 2 flushed slots in 1 cycle.

## Structure
- Package pipe_pkg holds:
  - the FSM enum (RUN, MEM_WAIT);
  - the forward-select localparams FWD_RF = 0, FWD_EXMEM = 1, FWD_MEMWB = 2;
  - the NOP control bundle constant.
- Sub-module fwd_unit is purely combinational, instanced twice (operand A and operand B). Everything else stays in the top module.

## Test plan
- EX/MEM rd = 5 with wreg, MEM/WB rd = 5 with wreg, idex_rs1 = 5 -> fwd_a = 1. Same with exmem_rd = 0 -> fwd_a = 2.
- Load in EX with rd = 3, ID reads dec_rs2 = 3 with use flag -> one cycle of stall_if = stall_id = flush_ex = 1. Next cycle (rmem gone) all 0. stall_cnt = 1.
- ex_redirect together with loaduse -> flush_id = flush_ex = 1, stall_if = 0, flush_cnt increments by 1.
- mem_req = 1, mem_ready low for 3 cycles -> all stalls and bubble_wb held 3 cycles, FSM in MEM_WAIT, then RUN on ready. A redirect held during the wait flushes on the release cycle.
- mem_ready held low for TIMEOUT cycles -> mem_timeout rises, stays 1 after the wait ends, and clears only on rst.
- rst asserted mid-MEM_WAIT with counters nonzero -> all counters 0, state RUN, mem_timeout 0 asynchronously.
